multicycle_ctrl_fsm: RTL

//  Multi-cycle sequencer for the RV32 subset datapath (R, I-ALU, lw, sw, lwi, beq/blt/bge).

---
 rtl/multicycle_ctrl_pkg.sv | 55 +++++
 rtl/multicycle_ctrl_fsm_mem_wait_timer.sv | 40 ++++
 rtl/multicycle_ctrl_fsm.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared constants for the multi-cycle RV32-subset sequencer.
//   - opcode constants for the supported instruction classes
//   - 3-bit state encoding (also exported on the debug state port)
//   - aluop codes, instruction-class enum, control-strobe bundle
package multicycle_ctrl_pkg;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_LWI  = 7'b0000111;
  localparam logic [6:0] OP_BR   = 7'b1100011;

  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] MEM    = 3'd3;
  localparam logic [2:0] WB     = 3'd4;
  localparam logic [2:0] HALT   = 3'd7;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;

  typedef enum logic [2:0] {
    CL_R, CL_IALU, CL_LW, CL_SW, CL_LWI, CL_BR, CL_ILL
  } iclass_t;

  typedef struct packed {
    logic       mem_req;
    logic       mem_sel;
    logic       memread;
    logic       memwrite;
    logic       ir_we;
    logic       pc_we;
    logic       pc_src;
    logic       regwrite;
    logic       memtoreg;
    logic       alusrc;
    logic [1:0] aluop;
  } ctrl_t;

  function automatic iclass_t op_class(input logic [6:0] op);
    case (op)
      OP_R:    return CL_R;
      OP_IALU: return CL_IALU;
      OP_LW:   return CL_LW;
      OP_SW:   return CL_SW;
      OP_LWI:  return CL_LWI;
      OP_BR:   return CL_BR;
      default: return CL_ILL;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_mem_wait_timer.sv
// Counts consecutive cycles of one memory request and flags expiry.
//   clk_i/rst_i : clock, synchronous active-high reset
//   req_i       : memory request currently asserted
//   ready_i     : memory completion this cycle (clears the count)
//   expire_o    : this is request cycle number MEM_TIMEOUT; the caller
//                 gives ready_i priority over expiry. Never set when
//                 MEM_TIMEOUT == 0.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_i,
  input  logic ready_i,
  output logic expire_o
);

  localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [CW-1:0] LIMIT = CW'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // cnt_q holds the number of request cycles already spent, so the
  // MEM_TIMEOUT-th cycle is the one that sees cnt_q == LIMIT.
  assign expire_o = (MEM_TIMEOUT != 0) && req_i && (cnt_q == LIMIT);

  always_comb begin
    cnt_d = '0;
    // Any cycle without a pending request (or with completion) restarts
    // the count, so each new request starts from zero.
    if ((MEM_TIMEOUT != 0) && req_i && !ready_i && !expire_o)
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle sequencer for the RV32 subset (R, I-ALU, lw, sw, lwi, branches).
// One micro-step per state: FETCH, DECODE, EXEC, MEM, WB; HALT on error.
// Inputs : clk_i, rst_i (sync, active high), opcode_i (inst[6:0]),
//          takebranch_i (ALU compare, EXEC), mem_ready_i (memory done).
// Outputs: mem_req_o/mem_sel_o/memread_o/memwrite_o (shared memory port),
//          ir_we_o, pc_we_o, pc_src_o, regwrite_o, memtoreg_o, alusrc_o,
//          aluop_o (datapath controls), state_o (debug), illegal_o and
//          timeout_o (sticky errors), retired_o (retired count, wraps).
module multicycle_ctrl_fsm
  import multicycle_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int RET_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [6:0]       opcode_i,
  input  logic             takebranch_i,
  input  logic             mem_ready_i,
  output logic             mem_req_o,
  output logic             mem_sel_o,
  output logic             memread_o,
  output logic             memwrite_o,
  output logic             ir_we_o,
  output logic             pc_we_o,
  output logic             pc_src_o,
  output logic             regwrite_o,
  output logic             memtoreg_o,
  output logic             alusrc_o,
  output logic [1:0]       aluop_o,
  output logic [2:0]       state_o,
  output logic             illegal_o,
  output logic             timeout_o,
  output logic [RET_W-1:0] retired_o
);

  logic [2:0]       state_q, state_d;
  logic [6:0]       op_q, op_d;
  logic             boot_q;
  logic             illegal_q, illegal_d;
  logic             timeout_q, timeout_d;
  logic [RET_W-1:0] retired_q, retired_d;
  logic             quiet;
  logic             expire;
  iclass_t          cls;
  iclass_t          dec_cls;
  ctrl_t            ctl;

  // Strobes are silenced while reset is asserted and for the first cycle
  // after it, so a request cut off by reset drops the cycle after reset
  // and no write can slip out once reset has been seen.
  assign quiet   = rst_i | boot_q;
  assign cls     = op_class(op_q);
  assign dec_cls = op_class(opcode_i);

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    (ctl.mem_req),
    .ready_i  (mem_ready_i),
    .expire_o (expire)
  );

  // Control strobes: state + latched opcode only, apart from ir_we/pc_we/
  // pc_src which follow mem_ready/takebranch in the same cycle.
  always_comb begin
    ctl = '0;
    if (!quiet) begin
      case (state_q)
        FETCH: begin
          ctl.mem_req = 1'b1;
          ctl.memread = 1'b1;
          ctl.ir_we   = mem_ready_i;
        end
        EXEC: begin
          case (cls)
            CL_R:    ctl.aluop = ALU_FUNCT;
            CL_IALU: begin ctl.aluop = ALU_FUNCT; ctl.alusrc = 1'b1; end
            CL_LW,
            CL_SW:   begin ctl.aluop = ALU_ADD;   ctl.alusrc = 1'b1; end
            CL_LWI:  ctl.aluop = ALU_ADD;
            CL_BR: begin
              ctl.aluop  = ALU_SUB;
              ctl.pc_we  = 1'b1;
              ctl.pc_src = takebranch_i;
            end
            default: ;
          endcase
        end
        MEM: begin
          ctl.mem_req  = 1'b1;
          ctl.mem_sel  = 1'b1;
          ctl.memread  = (cls == CL_LW) || (cls == CL_LWI);
          ctl.memwrite = (cls == CL_SW);
          ctl.pc_we    = (cls == CL_SW) && mem_ready_i;
        end
        WB: begin
          ctl.regwrite = 1'b1;
          ctl.memtoreg = (cls == CL_LW) || (cls == CL_LWI);
          ctl.pc_we    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    retired_d = retired_q + RET_W'(ctl.pc_we);
    case (state_q)
      FETCH: begin
        if (!boot_q) begin
          // Completion beats expiry in the same cycle.
          if (mem_ready_i)  state_d = DECODE;
          else if (expire) begin
            state_d   = HALT;
            timeout_d = 1'b1;
          end
        end
      end
      DECODE: begin
        op_d = opcode_i;
        if (dec_cls == CL_ILL) begin
          state_d   = HALT;
          illegal_d = 1'b1;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        case (cls)
          CL_BR:                state_d = FETCH;
          CL_LW, CL_SW, CL_LWI: state_d = MEM;
          default:              state_d = WB;
        endcase
      end
      MEM: begin
        if (mem_ready_i) state_d = (cls == CL_SW) ? FETCH : WB;
        else if (expire) begin
          state_d   = HALT;
          timeout_d = 1'b1;
        end
      end
      WB:      state_d = FETCH;
      HALT:    state_d = HALT;
      default: state_d = HALT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    boot_q <= rst_i;
    if (rst_i) begin
      state_q   <= FETCH;
      op_q      <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
      retired_q <= retired_d;
    end
  end

  assign mem_req_o  = ctl.mem_req;
  assign mem_sel_o  = ctl.mem_sel;
  assign memread_o  = ctl.memread;
  assign memwrite_o = ctl.memwrite;
  assign ir_we_o    = ctl.ir_we;
  assign pc_we_o    = ctl.pc_we;
  assign pc_src_o   = ctl.pc_src;
  assign regwrite_o = ctl.regwrite;
  assign memtoreg_o = ctl.memtoreg;
  assign alusrc_o   = ctl.alusrc;
  assign aluop_o    = ctl.aluop;
  assign state_o    = state_q;
  assign illegal_o  = illegal_q;
  assign timeout_o  = timeout_q;
  assign retired_o  = retired_q;

endmodule
